// File: rtl/fibo_index_finder.sv
// ============================================================================
// fibo_index_finder : walks F(0),F(1),... and reports the index matching VALUE
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fibo_index_finder #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] value,
    output logic            done,
    output logic            found,
    output logic [SIZE-1:0] index
);

    localparam int         c_aw       = SIZE + 2;
    localparam logic [1:0] c_s_idle   = 2'd0;
    localparam logic [1:0] c_s_calc   = 2'd1;
    localparam logic [1:0] c_s_finish = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [SIZE-1:0] r_val;
    logic [c_aw-1:0] r_a;
    logic [c_aw-1:0] r_b;
    logic [SIZE-1:0] r_idx;
    logic            r_done;
    logic            r_found;
    logic [SIZE-1:0] r_index;

    logic [c_aw-1:0] w_val_ext;
    logic            w_hit;
    logic            w_over;
    logic            w_load;
    logic            w_step;
    logic            w_done_nxt;
    logic            w_found_nxt;
    logic [SIZE-1:0] w_index_nxt;

    // a never exceeds the first Fibonacci number above val, so SIZE+2 bits never wrap
    assign w_val_ext = {2'b00, r_val};
    assign w_hit     = (r_a == w_val_ext);
    assign w_over    = (r_a > w_val_ext);
    assign w_load    = start && ((r_state == c_s_idle) || (r_state == c_s_finish));
    assign w_step    = (r_state == c_s_calc) && !w_hit && !w_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle:   w_state_nxt = start ? c_s_calc : c_s_idle;
            c_s_calc:   w_state_nxt = (w_hit || w_over) ? c_s_finish : c_s_calc;
            c_s_finish: w_state_nxt = start ? c_s_calc : c_s_idle;
            default:    w_state_nxt = c_s_idle;
        endcase
    end

    // Result registers only change on the edge that enters FINISH
    always_comb begin
        w_done_nxt  = (w_state_nxt == c_s_finish);
        w_found_nxt = r_found;
        w_index_nxt = r_index;
        if (r_state == c_s_calc) begin
            if (w_hit) begin
                w_found_nxt = 1'b1;
                w_index_nxt = r_idx;
            end else if (w_over) begin
                w_found_nxt = 1'b0;
                w_index_nxt = r_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done  <= 1'b0;
            r_found <= 1'b0;
            r_index <= '0;
        end else begin
            r_done  <= w_done_nxt;
            r_found <= w_found_nxt;
            r_index <= w_index_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
            r_a   <= '0;
            r_b   <= {{(c_aw-1){1'b0}}, 1'b1};
            r_idx <= '0;
        end else if (w_load) begin
            r_val <= value;
            r_a   <= '0;
            r_b   <= {{(c_aw-1){1'b0}}, 1'b1};
            r_idx <= '0;
        end else if (w_step) begin
            r_a   <= r_b;
            r_b   <= r_a + r_b;
            r_idx <= r_idx + 1'b1;
        end
    end

    assign done  = r_done;
    assign found = r_found;
    assign index = r_index;

endmodule

`default_nettype wire
